// File: rtl/tiger_conduit_pkg.sv
// Bit map, state encoding and byte-lane helpers for the Tiger data-memory conduit.
// Shared by the cache-side responder and the core-side wrapper.
package tiger_conduit_pkg;

  localparam int T2C_WIDTH     = 72;
  localparam int T2C_READ      = 0;
  localparam int T2C_WRITE     = 1;
  localparam int T2C_ADDR_LSB  = 2;
  localparam int T2C_ADDR_MSB  = 33;
  localparam int T2C_WDATA_LSB = 34;
  localparam int T2C_WDATA_MSB = 65;
  localparam int T2C_FLUSH     = 66;
  localparam int T2C_MEM8      = 67;
  localparam int T2C_MEM16     = 68;

  localparam int C2T_WIDTH     = 40;
  localparam int C2T_RDATA_LSB = 0;
  localparam int C2T_RDATA_MSB = 31;
  localparam int C2T_CAN_READ  = 32;
  localparam int C2T_CAN_WRITE = 33;
  localparam int C2T_CAN_FLUSH = 34;
  localparam int C2T_DSTALL    = 35;
  localparam int C2T_STALL_CPU = 36;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_FLUSH   = 2'd3
  } tiger_state_e;

  // Big-endian lanes: be[3] is [31:24], so byte offset 0 lands in the top lane.
  function automatic logic [3:0] lane_be(input logic mem8, input logic mem16,
                                         input logic [1:0] off);
    if (mem8)
      return 4'b1000 >> off;
    else if (mem16)
      return off[1] ? 4'b0011 : 4'b1100;
    else
      return 4'b1111;
  endfunction

  function automatic logic [31:0] lane_data(input logic mem8, input logic mem16,
                                            input logic [31:0] wdata);
    if (mem8)
      return {4{wdata[7:0]}};
    else if (mem16)
      return {2{wdata[15:0]}};
    else
      return wdata;
  endfunction

endpackage

// File: rtl/tiger_dmem_ram.sv
// Single-port word RAM with byte enables and a READ_LATENCY-deep read pipeline.
// Data for a read sampled at edge N appears on o_rdata in cycle N+READ_LATENCY.
module tiger_dmem_ram #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [3:0]            i_be,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem  [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] r_pipe [0:READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b])
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Stage 0 only loads on a read so the word is frozen while it walks the pipe.
  always_ff @(posedge clk) begin
    if (i_re)
      r_pipe[0] <= r_mem[i_addr];
    for (int i = 1; i < READ_LATENCY; i++)
      r_pipe[i] <= r_pipe[i-1];
  end

  assign o_rdata = r_pipe[READ_LATENCY-1];

endmodule

// File: rtl/tiger_dmem_responder.sv
// Cache-side endpoint of the Tiger dmem conduit: local word RAM, stall handshake, flush emulation.
// Optional counters/protocol-error flag under TIGER_DMEM_STATS_EN.
module tiger_dmem_responder
  import tiger_conduit_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [T2C_WIDTH-1:0] asi_TigertoCache_data,
  output logic [C2T_WIDTH-1:0] aso_CachetoTiger_data
`ifdef TIGER_DMEM_STATS_EN
  ,
  output logic [31:0]          stat_reads,
  output logic [31:0]          stat_writes,
  output logic [31:0]          stat_stall_cycles,
  output logic [0:0]           stat_proto_err
`endif
);

  localparam logic [1:0] LAT_INIT   = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;
  localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_CYCLES - 1);

  tiger_state_e r_state;
  logic [1:0]   r_lat_cnt;
  logic [7:0]   r_flush_cnt;
  logic [31:0]  r_readdata;
  logic         r_stall_cpu;

  logic        w_rd, w_wr, w_fl, w_m8, w_m16;
  logic [31:0] w_addr, w_wdata, w_ram_rdata;
  logic        w_idle, w_acc_fl, w_acc_wr, w_acc_rd, w_dstall;
  logic [C2T_WIDTH-1:0] w_c2t;
  logic        w_unused;

  assign w_rd    = asi_TigertoCache_data[T2C_READ];
  assign w_wr    = asi_TigertoCache_data[T2C_WRITE];
  assign w_fl    = asi_TigertoCache_data[T2C_FLUSH];
  assign w_m8    = asi_TigertoCache_data[T2C_MEM8];
  assign w_m16   = asi_TigertoCache_data[T2C_MEM16];
  assign w_addr  = asi_TigertoCache_data[T2C_ADDR_MSB:T2C_ADDR_LSB];
  assign w_wdata = asi_TigertoCache_data[T2C_WDATA_MSB:T2C_WDATA_LSB];

  assign w_unused = ^{asi_TigertoCache_data[T2C_WIDTH-1:T2C_MEM16+1], w_addr[31:ADDR_WIDTH+2]};

  assign w_idle   = (r_state == ST_IDLE);
  assign w_acc_fl = w_idle && !reset && w_fl;
  assign w_acc_wr = w_idle && !reset && !w_fl && w_wr;
  assign w_acc_rd = w_idle && !reset && !w_fl && !w_wr && w_rd;
  assign w_dstall = !reset && (w_acc_rd || r_state == ST_RD_WAIT || r_state == ST_FLUSH);

  tiger_dmem_ram #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_acc_wr),
    .i_re    (w_acc_rd),
    .i_be    (lane_be(w_m8, w_m16, w_addr[1:0])),
    .i_addr  (w_addr[ADDR_WIDTH+1:2]),
    .i_wdata (lane_data(w_m8, w_m16, w_wdata)),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_lat_cnt   <= 2'd0;
      r_flush_cnt <= 8'd0;
      r_readdata  <= 32'd0;
      r_stall_cpu <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fl) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FLUSH_INIT;
            r_stall_cpu <= 1'b1;
          end else if (!w_wr && w_rd) begin
            if (READ_LATENCY == 1) begin
              r_state <= ST_RD_DATA;
            end else begin
              r_state   <= ST_RD_WAIT;
              r_lat_cnt <= LAT_INIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (r_lat_cnt == 2'd0)
            r_state <= ST_RD_DATA;
          else
            r_lat_cnt <= r_lat_cnt - 2'd1;
        end
        ST_RD_DATA: begin
          r_readdata <= w_ram_rdata;
          r_state    <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (r_flush_cnt == 8'd0) begin
            r_state     <= ST_IDLE;
            r_stall_cpu <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // canRead doubles as the data-valid strobe, so it is also high in RD_DATA.
  always_comb begin
    w_c2t = '0;
    w_c2t[C2T_RDATA_MSB:C2T_RDATA_LSB] = (r_state == ST_RD_DATA) ? w_ram_rdata : r_readdata;
    w_c2t[C2T_CAN_READ]  = !reset && (w_idle || r_state == ST_RD_DATA);
    w_c2t[C2T_CAN_WRITE] = !reset && w_idle;
    w_c2t[C2T_CAN_FLUSH] = !reset && w_idle;
    w_c2t[C2T_DSTALL]    = w_dstall;
    w_c2t[C2T_STALL_CPU] = r_stall_cpu;
  end

  assign aso_CachetoTiger_data = w_c2t;

`ifdef TIGER_DMEM_STATS_EN
  logic [31:0] r_stat_reads, r_stat_writes, r_stat_stall;
  logic        r_stat_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_reads  <= 32'd0;
      r_stat_writes <= 32'd0;
      r_stat_stall  <= 32'd0;
      r_stat_err    <= 1'b0;
    end else begin
      if (w_acc_rd) r_stat_reads  <= r_stat_reads + 32'd1;
      if (w_acc_wr) r_stat_writes <= r_stat_writes + 32'd1;
      if (w_dstall) r_stat_stall  <= r_stat_stall + 32'd1;
      if (w_idle && ((w_rd && w_wr) || ((w_rd || w_wr) && w_m8 && w_m16)))
        r_stat_err <= 1'b1;
    end
  end

  assign stat_reads        = r_stat_reads;
  assign stat_writes       = r_stat_writes;
  assign stat_stall_cycles = r_stat_stall;
  assign stat_proto_err    = r_stat_err;
`endif

endmodule

// File: tb/tb_tiger_dmem_responder.sv
// Randomized bench for tiger_dmem_responder against a cycle-level behavioural model.
module tb_tiger_dmem_responder;

  localparam int AW = 12;
  localparam int RL = 2;
  localparam int FC = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [71:0] t2c = '0;
  logic [39:0] c2t;
`ifdef TIGER_DMEM_STATS_EN
  logic [31:0] s_rd, s_wr, s_st;
  logic [0:0]  s_pe;
`endif

  always #5 clk = ~clk;

  tiger_dmem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .FLUSH_CYCLES(FC)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .asi_TigertoCache_data (t2c),
    .aso_CachetoTiger_data (c2t)
`ifdef TIGER_DMEM_STATS_EN
    ,
    .stat_reads            (s_rd),
    .stat_writes           (s_wr),
    .stat_stall_cycles     (s_st),
    .stat_proto_err        (s_pe)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: kind 0 idle, 1 read in progress, 2 flush in progress; el = cycles since entry.
  logic [31:0] mdl_mem [0:(1<<AW)-1];
  int          kind = 0;
  int          el = 0;
  logic [31:0] rd_word = '0;
  logic [31:0] last_rd = '0;
  bit          mon_en = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << AW) - 1));
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic m8, input logic m16);
    int i;
    int sh;
    logic [31:0] w;
    i = widx(a);
    w = mdl_mem[i];
    if (m8) begin
      sh = 8 * (3 - int'(a & 3));
      w = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    end else if (m16) begin
      sh = ((a & 2) != 0) ? 0 : 16;
      w = (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
    end else begin
      w = d;
    end
    mdl_mem[i] = w;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      kind = 0; el = 0; last_rd = '0;
    end else if (kind == 0) begin
      if (t2c[66]) begin
        kind = 2; el = 1;
      end else if (t2c[1]) begin
        model_write(t2c[33:2], t2c[65:34], t2c[67], t2c[68]);
      end else if (t2c[0]) begin
        kind = 1; el = 1; rd_word = mdl_mem[widx(t2c[33:2])];
      end
    end else if (kind == 1) begin
      if (el == RL) begin last_rd = rd_word; kind = 0; end
      else el++;
    end else begin
      if (el == FC) kind = 0;
      else el++;
    end
  end

  always @(negedge clk) begin
    logic [39:0] e;
    if (mon_en) begin
      e = '0;
      if (!reset) begin
        e[31:0] = (kind == 1 && el == RL) ? rd_word : last_rd;
        e[32]   = (kind == 0) || (kind == 1 && el == RL);
        e[33]   = (kind == 0);
        e[34]   = (kind == 0);
        e[35]   = (kind == 0 && t2c[0] && !t2c[1] && !t2c[66]) || (kind == 1 && el < RL) || (kind == 2);
        e[36]   = (kind == 2);
        chk("bus", c2t, e);
      end else begin
        chk("can_in_reset", 40'(c2t[34:32]), 40'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic fl, input logic m8,
                         input logic m16, input logic [31:0] a, input logic [31:0] d);
    t2c = '0;
    t2c[0] = rd; t2c[1] = wr; t2c[66] = fl; t2c[67] = m8; t2c[68] = m16;
    t2c[33:2] = a; t2c[65:34] = d;
    t2c[71:69] = 3'($urandom);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic m8, input logic m16);
    set_req(1'b0, 1'b1, 1'b0, m8, m16, a, d);
    cyc();
    t2c = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] got, output int stalls);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, $urandom);
    stalls = 0; got = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!c2t[35]) begin got = c2t[31:0]; break; end
      stalls++;
      cyc();
    end
    cyc();
    t2c = '0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] got;
    int st;
    rd(a, got, st);
    chk(name, 40'(got), 40'(exp));
    chk("read_latency", 40'(st), 40'(RL));
  endtask

  task automatic flush_chk();
    int n;
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("canflush_before", 40'(c2t[34]), 40'd1);
    cyc();
    t2c = '0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!c2t[36]) break;
      n++;
      cyc();
    end
    chk("flush_len", 40'(n), 40'(FC));
    chk("canflush_after", 40'(c2t[34]), 40'd1);
    cyc();
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    int st;
    int op;
    int sz;
    for (int i = 0; i < (1 << AW); i++) mdl_mem[i] = '0;
    repeat (3) cyc();
    reset = 1'b0;
    mon_en = 1;
    @(negedge clk);
    chk("reset_state", c2t, 40'h07_0000_0000);
    cyc();

    for (int i = 0; i < (1 << AW); i++) wr(32'(i) << 2, 32'd0, 1'b0, 1'b0);

    wr(32'h40, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("model_pin_word", 40'(mdl_mem[16]), 40'hDEADBEEF);
    rd_chk("word_rd", 32'h40, 32'hDEADBEEF);

    wr(32'h101, 32'h000000AA, 1'b1, 1'b0);
    rd_chk("byte_wr", 32'h100, 32'h00AA0000);
    wr(32'h102, 32'h00001234, 1'b0, 1'b1);
    rd_chk("half_wr", 32'h100, 32'h00AA1234);
    wr(32'h100, 32'h00000011, 1'b1, 1'b0);
    wr(32'h103, 32'h00000022, 1'b1, 1'b0);
    rd_chk("byte_lanes_0_3", 32'h100, 32'h11AA1222);

    flush_chk();
    rd_chk("flush_keeps_ram", 32'h40, 32'hDEADBEEF);

    set_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h5);
    @(negedge clk);
    chk("rw_no_stall", 40'(c2t[35]), 40'd0);
    cyc();
    t2c = '0;
    rd_chk("rw_as_write", 32'h80, 32'h5);
`ifdef TIGER_DMEM_STATS_EN
    chk("proto_err", 40'(s_pe), 40'd1);
`endif

    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_mid_read_can", 40'(c2t[34:32]), 40'd0);
    chk("rst_mid_read_stall", 40'(c2t[35]), 40'd0);
    cyc();
    reset = 1'b0;
    t2c = '0;
    @(negedge clk);
    chk("after_rst_can", 40'(c2t[34:32]), 40'd7);
    cyc();

    reset = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h12345678);
    cyc();
    reset = 1'b0;
    t2c = '0;
    cyc();
    rd_chk("rst_drops_write", 32'h40, 32'hDEADBEEF);

    wr(32'h4000, 32'h77, 1'b0, 1'b0);
    rd_chk("alias", 32'h0, 32'h77);

    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 99);
      sz = $urandom_range(0, 2);
      if (op < 40) begin
        wr(rnd_addr(), $urandom, sz == 1, sz == 2);
      end else if (op < 75) begin
        rd(rnd_addr(), got, st);
        chk("rand_read_latency", 40'(st), 40'(RL));
      end else if (op < 82) begin
        flush_chk();
      end else if (op < 92) begin
        set_req(1'b1, 1'b1, 1'b0, sz == 1, sz == 2, rnd_addr(), $urandom);
        cyc();
        t2c = '0;
      end else begin
        repeat ($urandom_range(1, 3)) cyc();
      end
    end

    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
